// File: rtl/vector_pkg.sv
// Shared definitions for the vector rasteriser: FSM state encoding and the
// width of the per-polyline segment-count field.
package vector_pkg;

    localparam int S_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CLEAR       = 4'd1,
        ST_FETCH_COUNT = 4'd2,
        ST_FETCH_ATTR  = 4'd3,
        ST_FETCH_X0    = 4'd4,
        ST_FETCH_Y0    = 4'd5,
        ST_FETCH_X     = 4'd6,
        ST_FETCH_Y     = 4'd7,
        ST_SETUP       = 4'd8,
        ST_DRAW        = 4'd9,
        ST_DONE        = 4'd10
    } state_t;

endpackage

// File: rtl/vector_bresenham_step.sv
// One integer Bresenham step: next (x, y, err) from the current point, error
// term and the segment's fixed deltas/directions. Purely combinational.
module vector_bresenham_step #(
    parameter int COORD_WIDTH = 8
) (
    input  logic [COORD_WIDTH-1:0]        x_i,
    input  logic [COORD_WIDTH-1:0]        y_i,
    input  logic signed [COORD_WIDTH+1:0] err_i,
    input  logic signed [COORD_WIDTH+1:0] dx_i,
    input  logic signed [COORD_WIDTH+1:0] dy_i,
    input  logic                          sx_neg_i,
    input  logic                          sy_neg_i,
    output logic [COORD_WIDTH-1:0]        x_o,
    output logic [COORD_WIDTH-1:0]        y_o,
    output logic signed [COORD_WIDTH+1:0] err_o
);

    logic signed [COORD_WIDTH+1:0] e2;

    always_comb begin
        e2    = err_i <<< 1;
        x_o   = x_i;
        y_o   = y_i;
        err_o = err_i;
        if (e2 >= dy_i) begin
            err_o = err_o + dy_i;
            x_o   = sx_neg_i ? (x_i - COORD_WIDTH'(1)) : (x_i + COORD_WIDTH'(1));
        end
        if (e2 <= dx_i) begin
            err_o = err_o + dx_i;
            y_o   = sy_neg_i ? (y_i - COORD_WIDTH'(1)) : (y_i + COORD_WIDTH'(1));
        end
    end

endmodule

// File: rtl/vector_raster.sv
// Display-list line rasteriser: optional framebuffer clear, then walks polylines
// from list RAM and draws them with Bresenham through a ready/stall write port.
module vector_raster
    import vector_pkg::*;
#(
    parameter int                     COORD_WIDTH     = 8,
    parameter int                     LIST_ADDR_WIDTH = 9,
    parameter int                     PIXEL_WIDTH     = 8,
    parameter logic [PIXEL_WIDTH-1:0] CLEAR_VALUE     = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         clear_en,
    output logic [LIST_ADDR_WIDTH-1:0]   list_addr,
    input  logic [COORD_WIDTH-1:0]       list_data,
    output logic [2*COORD_WIDTH-1:0]     fb_addr,
    output logic [PIXEL_WIDTH-1:0]       fb_data,
    output logic                         fb_we,
    input  logic                         fb_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int CW    = COORD_WIDTH;
    localparam int SW    = COORD_WIDTH + 2;
    localparam int CNT_W = (COORD_WIDTH < S_WIDTH) ? COORD_WIDTH : S_WIDTH;

    state_t                     state_q, state_d;
    logic                       rd_ph_q, rd_ph_d;
    logic [LIST_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2*CW-1:0]            clr_q, clr_d;
    logic [CW-1:0]              px_q, px_d, py_q, py_d;
    logic [S_WIDTH-1:0]         rem_q, rem_d;
    logic                       first_q, first_d;
    logic                       ovr_q, ovr_d;

    logic [CW-1:0]              ex_q, ex_d, ey_q, ey_d;
    logic signed [SW-1:0]       err_q, err_d, dx_q, dx_d, dy_q, dy_d;
    logic                       sxn_q, sxn_d, syn_q, syn_d;
    logic [PIXEL_WIDTH-1:0]     col_q, col_d;

    logic [S_WIDTH-1:0]         list_count;
    logic [PIXEL_WIDTH-1:0]     list_colour;

    generate
        if (CNT_W < S_WIDTH) begin : g_cnt_narrow
            assign list_count = {{(S_WIDTH-CNT_W){1'b0}}, list_data[CNT_W-1:0]};
        end else begin : g_cnt_full
            assign list_count = list_data[S_WIDTH-1:0];
        end
        if (PIXEL_WIDTH > COORD_WIDTH) begin : g_col_wide
            assign list_colour = {{(PIXEL_WIDTH-COORD_WIDTH){1'b0}}, list_data};
        end else begin : g_col_narrow
            assign list_colour = list_data[PIXEL_WIDTH-1:0];
        end
    endgenerate

    // Segment setup terms, valid while the current and end points are latched.
    logic signed [SW-1:0] ddx, ddy, su_dx, su_dy, su_err;

    assign ddx    = $signed({2'b00, ex_q}) - $signed({2'b00, px_q});
    assign ddy    = $signed({2'b00, ey_q}) - $signed({2'b00, py_q});
    assign su_dx  = ddx[SW-1] ? -ddx : ddx;
    assign su_dy  = ddy[SW-1] ? ddy : -ddy;
    assign su_err = su_dx + su_dy;

    logic                 in_setup;
    logic signed [SW-1:0] st_err_in, st_dx_in, st_dy_in, st_err;
    logic                 st_sxn_in, st_syn_in;
    logic [CW-1:0]        st_x, st_y;

    assign in_setup  = (state_q == ST_SETUP);
    assign st_err_in = in_setup ? su_err     : err_q;
    assign st_dx_in  = in_setup ? su_dx      : dx_q;
    assign st_dy_in  = in_setup ? su_dy      : dy_q;
    assign st_sxn_in = in_setup ? ddx[SW-1]  : sxn_q;
    assign st_syn_in = in_setup ? ddy[SW-1]  : syn_q;

    vector_bresenham_step #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_step (
        .x_i      (px_q),
        .y_i      (py_q),
        .err_i    (st_err_in),
        .dx_i     (st_dx_in),
        .dy_i     (st_dy_in),
        .sx_neg_i (st_sxn_in),
        .sy_neg_i (st_syn_in),
        .x_o      (st_x),
        .y_o      (st_y),
        .err_o    (st_err)
    );

    logic at_end, last_addr;

    assign at_end    = (px_q == ex_q) && (py_q == ey_q);
    assign last_addr = &addr_q;

    always_comb begin
        state_d = state_q;
        rd_ph_d = rd_ph_q;
        addr_d  = addr_q;
        clr_d   = clr_q;
        px_d    = px_q;
        py_d    = py_q;
        rem_d   = rem_q;
        first_d = first_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        col_d   = col_q;
        ovr_d   = frame_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d  = '0;
                    rd_ph_d = 1'b0;
                    clr_d   = '0;
                    state_d = clear_en ? ST_CLEAR : ST_FETCH_COUNT;
                end
            end

            ST_CLEAR: begin
                if (fb_ready) begin
                    if (&clr_q) state_d = ST_FETCH_COUNT;
                    else        clr_d   = clr_q + (2*CW)'(1);
                end
            end

            // Each list word: one cycle presenting the address, one capturing data.
            ST_FETCH_COUNT, ST_FETCH_ATTR, ST_FETCH_X0,
            ST_FETCH_Y0, ST_FETCH_X, ST_FETCH_Y: begin
                if (!rd_ph_q) begin
                    rd_ph_d = 1'b1;
                end else begin
                    rd_ph_d = 1'b0;
                    if (!last_addr) addr_d = addr_q + LIST_ADDR_WIDTH'(1);
                    case (state_q)
                        ST_FETCH_COUNT: begin
                            rem_d   = list_count;
                            state_d = (list_count == '0) ? ST_DONE : ST_FETCH_ATTR;
                        end
                        ST_FETCH_ATTR: begin
                            col_d   = list_colour;
                            state_d = ST_FETCH_X0;
                        end
                        ST_FETCH_X0: begin
                            px_d    = list_data;
                            state_d = ST_FETCH_Y0;
                        end
                        ST_FETCH_Y0: begin
                            py_d    = list_data;
                            first_d = 1'b1;
                            state_d = ST_FETCH_X;
                        end
                        ST_FETCH_X: begin
                            ex_d    = list_data;
                            state_d = ST_FETCH_Y;
                        end
                        default: begin
                            ey_d    = list_data;
                            state_d = ST_SETUP;
                        end
                    endcase
                    // Running off the end of list RAM terminates the pass.
                    if (last_addr) state_d = ST_DONE;
                end
            end

            ST_SETUP: begin
                dx_d    = su_dx;
                dy_d    = su_dy;
                sxn_d   = ddx[SW-1];
                syn_d   = ddy[SW-1];
                rem_d   = rem_q - S_WIDTH'(1);
                first_d = 1'b0;
                if (first_q) begin
                    err_d   = su_err;
                    state_d = ST_DRAW;
                end else if (at_end) begin
                    state_d = (rem_q != S_WIDTH'(1)) ? ST_FETCH_X : ST_FETCH_COUNT;
                end else begin
                    // Shared vertex was already drawn by the previous segment.
                    px_d    = st_x;
                    py_d    = st_y;
                    err_d   = st_err;
                    state_d = ST_DRAW;
                end
            end

            ST_DRAW: begin
                if (fb_ready) begin
                    if (at_end) begin
                        state_d = (rem_q != '0) ? ST_FETCH_X : ST_FETCH_COUNT;
                    end else begin
                        px_d  = st_x;
                        py_d  = st_y;
                        err_d = st_err;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rd_ph_q <= 1'b0;
            addr_q  <= '0;
            clr_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_ph_q <= rd_ph_d;
            addr_q  <= addr_d;
            clr_q   <= clr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            ovr_q   <= ovr_d;
        end
    end

    // Segment datapath: always loaded before use, so no reset needed.
    always_ff @(posedge clk) begin
        ex_q  <= ex_d;
        ey_q  <= ey_d;
        err_q <= err_d;
        dx_q  <= dx_d;
        dy_q  <= dy_d;
        sxn_q <= sxn_d;
        syn_q <= syn_d;
        col_q <= col_d;
    end

    assign list_addr = addr_q;
    assign fb_we     = (state_q == ST_CLEAR) || (state_q == ST_DRAW);
    assign fb_addr   = (state_q == ST_CLEAR) ? clr_q : {py_q, px_q};
    assign fb_data   = (state_q == ST_CLEAR) ? CLEAR_VALUE :
                       (state_q == ST_DRAW)  ? col_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_vector_raster.sv
// Scoreboard bench for vector_raster: expected framebuffer writes are queued
// from a software Bresenham walk of each display list and popped per write.
`timescale 1ns/1ps
module tb_vector_raster;

    localparam int CW  = 8;
    localparam int LAW = 9;
    localparam int PW  = 8;

    logic           clk = 1'b0;
    logic           reset, frame_start, clear_en, fb_ready;
    logic [LAW-1:0] list_addr;
    logic [CW-1:0]  list_data = '0;
    logic [2*CW-1:0] fb_addr;
    logic [PW-1:0]  fb_data;
    logic           fb_we, busy, done, overrun;

    logic           frame_start4, fb_ready4;
    logic [LAW-1:0] list_addr4;
    logic [3:0]     list_data4;
    logic [7:0]     fb_addr4;
    logic [7:0]     fb_data4;
    logic           fb_we4, busy4, done4, overrun4;

    logic [7:0]     mem [512];
    logic [23:0]    exp_q [$];
    int             checks = 0;
    int             errors = 0;
    int             wr_count = 0;
    int             ovr_count = 0;
    bit             rand_ready = 1'b0;

    initial forever #5 clk = ~clk;

    vector_raster #(.COORD_WIDTH(CW), .LIST_ADDR_WIDTH(LAW), .PIXEL_WIDTH(PW), .CLEAR_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .clear_en(clear_en),
        .list_addr(list_addr), .list_data(list_data), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .fb_ready(fb_ready), .busy(busy), .done(done), .overrun(overrun)
    );

    vector_raster #(.COORD_WIDTH(4), .LIST_ADDR_WIDTH(LAW), .PIXEL_WIDTH(8), .CLEAR_VALUE(8'h00)) dut4 (
        .clk(clk), .reset(reset), .frame_start(frame_start4), .clear_en(clear_en),
        .list_addr(list_addr4), .list_data(list_data4), .fb_addr(fb_addr4), .fb_data(fb_data4),
        .fb_we(fb_we4), .fb_ready(fb_ready4), .busy(busy4), .done(done4), .overrun(overrun4)
    );

    always @(posedge clk) list_data <= mem[list_addr];

    initial begin
        fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Write monitor: pops the scoreboard on every accepted write and checks
    // that a stalled write holds its address/data.
    initial begin
        bit          stall_prev = 1'b0;
        logic [15:0] pa = '0;
        logic [7:0]  pd = '0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                checks++;
                if (fb_we !== 1'b1 || fb_addr !== pa || fb_data !== pd) begin
                    errors++;
                    $display("FAIL stall_hold: got we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                             fb_we, fb_addr, fb_data, pa, pd);
                end
            end
            if (overrun === 1'b1) ovr_count++;
            if (fb_we === 1'b1 && fb_ready === 1'b1) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_extra: got addr=%h data=%h, required no write", fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({fb_addr, fb_data} !== e) begin
                        errors++;
                        $display("FAIL write_seq: got addr=%h data=%h, required addr=%h data=%h",
                                 fb_addr, fb_data, e[23:8], e[7:0]);
                    end
                end
            end
            stall_prev = (fb_we === 1'b1) && (fb_ready !== 1'b1);
            pa = fb_addr;
            pd = fb_data;
        end
    end

    task automatic model_segment(input int x0, input int y0, input int x1, input int y1,
                                 input bit skip_first, input int colour);
        int x, y, dx, dy, sx, sy, err, e2;
        bit first;
        x = x0; y = y0; first = 1'b1;
        dx = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        dy = (y1 >= y0) ? (y0 - y1) : (y1 - y0);
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        forever begin
            if (!(skip_first && first)) exp_q.push_back({y[7:0], x[7:0], colour[7:0]});
            first = 1'b0;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic load_list(input int w[$]);
        int a, s, col, cx, cy, nx, ny;
        foreach (mem[i]) mem[i] = 8'h00;
        foreach (w[i]) mem[i] = 8'(w[i]);
        exp_q.delete();
        a = 0;
        while (a < w.size() && w[a] != 0) begin
            s = w[a]; col = w[a+1]; cx = w[a+2]; cy = w[a+3];
            a += 4;
            for (int k = 0; k < s; k++) begin
                nx = w[a]; ny = w[a+1];
                a += 2;
                model_segment(cx, cy, nx, ny, k != 0, col);
                cx = nx; cy = ny;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles, output bit got_done);
        cycles = 0;
        got_done = 1'b0;
        while (cycles < max_cycles && !got_done) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) got_done = 1'b1;
        end
    endtask

    task automatic run_pass(input int max_cycles, output int cycles, output bit got_done);
        wr_count = 0;
        pulse_start();
        wait_done(max_cycles, cycles, got_done);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_start = 1'b0; frame_start4 = 1'b0; clear_en = 1'b0;
        fb_ready4 = 1'b1; list_data4 = 4'h0;
        #12;
        checks += 9;
        if (list_addr !== '0) begin errors++; $display("FAIL reset_list_addr: got %h, required 0", list_addr); end
        if (fb_addr !== '0)   begin errors++; $display("FAIL reset_fb_addr: got %h, required 0", fb_addr); end
        if (fb_data !== '0)   begin errors++; $display("FAIL reset_fb_data: got %h, required 0", fb_data); end
        if (fb_we !== 1'b0)   begin errors++; $display("FAIL reset_fb_we: got %b, required 0", fb_we); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        if (fb_we4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++; $display("FAIL reset_dut4: got we=%b busy=%b, required 0 0", fb_we4, busy4);
        end
        if (list_addr4 !== '0 || overrun4 !== 1'b0) begin
            errors++; $display("FAIL reset_dut4_addr: got addr=%h ovr=%b, required 0 0", list_addr4, overrun4);
        end
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_horizontal();
        int w[$];
        int cyc;
        bit got;
        w = {1, 8'h0F, 2, 5, 6, 5, 0};
        load_list(w);
        run_pass(200, cyc, got);
        checks += 4;
        if (!got) begin errors++; $display("FAIL horiz_done: got no done, required done"); end
        if (cyc < 15 || cyc > 40) begin errors++; $display("FAIL horiz_latency: got %0d cycles, required 15..40", cyc); end
        if (wr_count !== 5) begin errors++; $display("FAIL horiz_writes: got %0d, required 5", wr_count); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL horiz_missing: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_diagonal(input bit stall);
        int w[$];
        int cyc;
        bit got;
        w = {2, 8'hFF, 0, 0, 3, 3, 3, 10, 0};
        load_list(w);
        rand_ready = stall;
        run_pass(600, cyc, got);
        rand_ready = 1'b0;
        checks += 4;
        if (!got) begin errors++; $display("FAIL diag_done: got no done (stall=%0d), required done", stall); end
        if (wr_count !== 11) begin errors++; $display("FAIL diag_writes: got %0d (stall=%0d), required 11", wr_count, stall); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL diag_missing: got %0d left, required 0", exp_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL diag_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_reverse();
        int w[$];
        int cyc;
        bit got;
        w = {1, 8'h80, 7, 2, 1, 0, 0};
        load_list(w);
        run_pass(200, cyc, got);
        checks += 3;
        if (!got) begin errors++; $display("FAIL rev_done: got no done, required done"); end
        if (wr_count !== 7) begin errors++; $display("FAIL rev_writes: got %0d, required 7", wr_count); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL rev_missing: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int w[$];
        int cyc, n;
        bit got;
        w = {1, 8'h33, 0, 0, 40, 20, 0};
        load_list(w);
        wr_count = 0;
        ovr_count = 0;
        pulse_start();
        n = 0;
        while (wr_count < 5 && n < 200) begin @(negedge clk); n++; end
        pulse_start();
        wait_done(400, cyc, got);
        @(negedge clk);
        checks += 4;
        if (!got) begin errors++; $display("FAIL ovr_done: got no done, required done"); end
        if (ovr_count !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d, required 1", ovr_count); end
        if (wr_count !== 41) begin errors++; $display("FAIL ovr_writes: got %0d, required 41", wr_count); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_missing: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w[$];
        int cyc, n;
        bit got;
        w = {1, 8'h44, 0, 0, 50, 0, 0};
        load_list(w);
        wr_count = 0;
        pulse_start();
        n = 0;
        while (wr_count < 3 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (wr_count < 3) begin errors++; $display("FAIL rstmid_reach_draw: got %0d writes, required 3", wr_count); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b, required 0", fb_we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        if (list_addr !== '0) begin errors++; $display("FAIL rstmid_addr: got %h, required 0", list_addr); end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        w = {1, 8'h0F, 2, 5, 6, 5, 0};
        load_list(w);
        wr_count = 0;
        pulse_start();
        @(negedge clk);
        checks++;
        if (list_addr !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_addr: got addr=%h busy=%b, required addr=0 busy=1", list_addr, busy);
        end
        wait_done(200, cyc, got);
        @(negedge clk);
        checks += 3;
        if (!got) begin errors++; $display("FAIL restart_done: got no done, required done"); end
        if (wr_count !== 5) begin errors++; $display("FAIL restart_writes: got %0d, required 5", wr_count); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missing: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_addr_bound();
        int cyc;
        bit got;
        foreach (mem[i]) mem[i] = 8'd5;
        mem[0] = 8'd255;
        mem[1] = 8'h5A;
        exp_q.delete();
        exp_q.push_back({8'd5, 8'd5, 8'h5A});
        run_pass(4000, cyc, got);
        checks += 4;
        if (!got) begin errors++; $display("FAIL bound_done: got no done, required done"); end
        if (wr_count !== 1) begin errors++; $display("FAIL bound_writes: got %0d, required 1", wr_count); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL bound_missing: got %0d left, required 0", exp_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bound_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_clear();
        int idx, n;
        bit got;
        clear_en = 1'b1;
        @(posedge clk);
        #1 frame_start4 = 1'b1;
        @(posedge clk);
        #1 frame_start4 = 1'b0;
        clear_en = 1'b0;
        idx = 0; n = 0; got = 1'b0;
        while (!got && n < 600) begin
            @(negedge clk);
            n++;
            if (fb_we4 === 1'b1 && fb_ready4 === 1'b1) begin
                checks++;
                if (fb_addr4 !== 8'(idx) || fb_data4 !== 8'h00) begin
                    errors++;
                    $display("FAIL clear_write: got addr=%h data=%h, required addr=%h data=00", fb_addr4, fb_data4, 8'(idx));
                end
                idx++;
            end
            if (done4 === 1'b1) got = 1'b1;
        end
        checks += 2;
        if (!got) begin errors++; $display("FAIL clear_done: got no done, required done"); end
        if (idx !== 256) begin errors++; $display("FAIL clear_count: got %0d, required 256", idx); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_diagonal(1'b0);
        test_reverse();
        test_diagonal(1'b1);
        test_overrun();
        test_reset_mid();
        test_addr_bound();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
